// File: rtl/pid_loop_sequencer.sv
// rtl/pid_loop_sequencer.sv - one PID iteration per sample tick: PV read, calc, output write.
// Watches each phase for a missing done and flags sample overruns.
module pid_loop_sequencer #(
  parameter int PERIOD_W = 8,
  parameter int TIMEOUT  = 64,
  parameter int TMO_W    = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_flags,
  output logic                pv_start,
  input  logic                pv_done,
  output logic                calc_start,
  input  logic                calc_done,
  output logic                out_start,
  input  logic                out_done,
  output logic                busy,
  output logic [1:0]          phase,
  output logic                overrun,
  output logic                fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PV   = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]          r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic [TMO_W-1:0]    r_wd;
  logic                r_pv_start;
  logic                r_calc_start;
  logic                r_out_start;
  logic                r_overrun;
  logic                r_fault;

  logic w_tick;
  logic w_done;
  logic w_expire;

  // >= rather than == so a period lowered below the running count fires at once
  assign w_tick = en && (r_cnt >= period);

  assign w_done = ((r_state == S_PV)   && pv_done)   ||
                  ((r_state == S_CALC) && calc_done) ||
                  ((r_state == S_OUT)  && out_done);

  assign w_expire = (r_state != S_IDLE) && (r_wd == TMO_W'(TIMEOUT - 1)) && !w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wd         <= '0;
      r_pv_start   <= 1'b0;
      r_calc_start <= 1'b0;
      r_out_start  <= 1'b0;
      r_overrun    <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      if (!en) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_pv_start   <= 1'b0;
      r_calc_start <= 1'b0;
      r_out_start  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_tick && !r_fault) begin
            r_state    <= S_PV;
            r_pv_start <= 1'b1;
            r_wd       <= '0;
          end
        end
        S_PV: begin
          if (pv_done) begin
            r_state      <= S_CALC;
            r_calc_start <= 1'b1;
            r_wd         <= '0;
          end else if (w_expire) begin
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_CALC: begin
          if (calc_done) begin
            r_state     <= S_OUT;
            r_out_start <= 1'b1;
            r_wd        <= '0;
          end else if (w_expire) begin
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: begin
          if (out_done) begin
            r_state <= S_IDLE;
            r_wd    <= '0;
          end else if (w_expire) begin
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
      endcase

      // set events take priority over a same-cycle clear
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end else if (clr_flags) begin
        r_overrun <= 1'b0;
      end

      if (w_expire) begin
        r_fault <= 1'b1;
      end else if (clr_flags) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign pv_start   = r_pv_start;
  assign calc_start = r_calc_start;
  assign out_start  = r_out_start;
  assign busy       = (r_state != S_IDLE);
  assign phase      = r_state;
  assign overrun    = r_overrun;
  assign fault      = r_fault;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb/tb_pid_loop_sequencer.sv - directed vector bench for pid_loop_sequencer.
// Engines are modelled as fixed-latency responders driven from the step task.
module tb_pid_loop_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [7:0] period = 8'd0;
  logic       clr_flags = 1'b0;
  logic       pv_done = 1'b0;
  logic       calc_done = 1'b0;
  logic       out_done = 1'b0;
  logic       pv_start, calc_start, out_start, busy, overrun, fault;
  logic [1:0] phase;

  pid_loop_sequencer #(.PERIOD_W(8), .TIMEOUT(64), .TMO_W(7)) dut (
    .clk(clk), .reset(reset), .en(en), .period(period), .clr_flags(clr_flags),
    .pv_start(pv_start), .pv_done(pv_done),
    .calc_start(calc_start), .calc_done(calc_done),
    .out_start(out_start), .out_done(out_done),
    .busy(busy), .phase(phase), .overrun(overrun), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_pv = 2, lat_calc = 2, lat_out = 2;
  int cd_pv = -1, cd_calc = -1, cd_out = -1;

  typedef struct {
    int period;
    int lp, lc, lo;
    int e_first, e_calc, e_out, e_idle, e_next, e_ov;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one clock; inputs change 1 time unit after the edge, engines react in the same slot
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pv_done = 1'b0; calc_done = 1'b0; out_done = 1'b0; clr_flags = 1'b0;
    if (pv_start)   cd_pv   = lat_pv;
    if (calc_start) cd_calc = lat_calc;
    if (out_start)  cd_out  = lat_out;
    if (cd_pv == 0) begin pv_done = 1'b1; cd_pv = -1; end
    else if (cd_pv > 0) cd_pv--;
    if (cd_calc == 0) begin calc_done = 1'b1; cd_calc = -1; end
    else if (cd_calc > 0) cd_calc--;
    if (cd_out == 0) begin out_done = 1'b1; cd_out = -1; end
    else if (cd_out > 0) cd_out--;
  endtask

  task automatic apply_reset();
    reset = 1'b1; en = 1'b0;
    cd_pv = -1; cd_calc = -1; cd_out = -1;
    step();
    step();
    cd_pv = -1; cd_calc = -1; cd_out = -1;
  endtask

  task automatic start_run(input int p, input int lp, input int lc, input int lo);
    period = 8'(p);
    lat_pv = lp; lat_calc = lc; lat_out = lo;
    reset = 1'b0;
    en = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int first_pv, c_calc, c_out, c_idle, c_next;
    int fault_cyc, fault_phase, n_out, n_pv, n;

    vecs[0] = '{period: 9, lp: 2, lc: 2, lo: 2, e_first: 10, e_calc: 3, e_out: 6, e_idle: 9,  e_next: 10, e_ov: 0};
    vecs[1] = '{period: 3, lp: 4, lc: 4, lo: 4, e_first: 4,  e_calc: 5, e_out: 10, e_idle: 15, e_next: 16, e_ov: 1};
    vecs[2] = '{period: 0, lp: 0, lc: 0, lo: 0, e_first: 1,  e_calc: 1, e_out: 2, e_idle: 3,  e_next: 4,  e_ov: 1};
    vecs[3] = '{period: 5, lp: 1, lc: 0, lo: 3, e_first: 6,  e_calc: 2, e_out: 3, e_idle: 7,  e_next: 12, e_ov: 1};

    apply_reset();
    chk("rst_pv_start", int'(pv_start), 0);
    chk("rst_calc_start", int'(calc_start), 0);
    chk("rst_out_start", int'(out_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_fault", int'(fault), 0);

    for (int v = 0; v < 4; v++) begin
      apply_reset();
      start_run(vecs[v].period, vecs[v].lp, vecs[v].lc, vecs[v].lo);
      first_pv = -1; c_calc = -1; c_out = -1; c_idle = -1; c_next = -1;
      for (int k = 0; k < 80 && c_next < 0; k++) begin
        step();
        if (c_out >= 0 && c_idle < 0 && phase == 2'd0) c_idle = cyc;
        if (pv_start) begin
          if (first_pv < 0) first_pv = cyc;
          else if (c_next < 0) c_next = cyc;
        end
        if (calc_start && c_calc < 0) c_calc = cyc;
        if (out_start && c_out < 0) c_out = cyc;
      end
      chk($sformatf("v%0d_first_pv", v), first_pv, vecs[v].e_first);
      chk($sformatf("v%0d_calc_off", v), c_calc - first_pv, vecs[v].e_calc);
      chk($sformatf("v%0d_out_off", v), c_out - first_pv, vecs[v].e_out);
      chk($sformatf("v%0d_idle_off", v), c_idle - first_pv, vecs[v].e_idle);
      chk($sformatf("v%0d_next_off", v), c_next - first_pv, vecs[v].e_next);
      chk($sformatf("v%0d_overrun", v), int'(overrun), vecs[v].e_ov);
      chk($sformatf("v%0d_fault", v), int'(fault), 0);
    end

    // overrun clear
    clr_flags = 1'b1;
    step();
    chk("clr_overrun", int'(overrun), 0);

    // calc engine never answers: watchdog fault after 64 cycles in CALC
    apply_reset();
    start_run(9, 1, -1, 1);
    fault_cyc = -1; fault_phase = -1; n_out = 0; n_pv = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (fault && fault_cyc < 0) begin fault_cyc = cyc; fault_phase = int'(phase); end
      if (out_start) n_out++;
      if (pv_start) n_pv++;
    end
    chk("tmo_fault_cycle", fault_cyc, 76);
    chk("tmo_phase_idle", fault_phase, 0);
    chk("tmo_no_out_start", n_out, 0);
    chk("tmo_pv_count", n_pv, 1);
    chk("tmo_busy", int'(busy), 0);
    clr_flags = 1'b1;
    step();
    chk("tmo_clr_fault", int'(fault), 0);
    n = 0;
    for (int k = 0; k < 15 && n == 0; k++) begin
      step();
      if (pv_start) n = 1;
    end
    chk("tmo_resume_pv", n, 1);

    // stray done pulses while in PV are ignored
    apply_reset();
    start_run(4, 3, 1, 1);
    n = 0;
    for (int k = 0; k < 20 && n == 0; k++) begin
      step();
      if (pv_start) n = cyc;
    end
    out_done = 1'b1; calc_done = 1'b1;
    step();
    chk("stray_phase_pv", int'(phase), 1);
    first_pv = n; c_calc = -1;
    for (int k = 0; k < 20 && c_calc < 0; k++) begin
      if (calc_start) c_calc = cyc;
      else step();
    end
    chk("stray_calc_off", c_calc - first_pv, 4);

    // reset during OUT aborts the iteration and clears flags
    apply_reset();
    start_run(2, 2, 2, 2);
    n = 0;
    for (int k = 0; k < 60 && n == 0; k++) begin
      step();
      if (phase == 2'd3) n = 1;
    end
    chk("rst_out_reached", n, 1);
    chk("rst_out_overrun_pre", int'(overrun), 1);
    reset = 1'b1;
    step();
    chk("rstout_phase", int'(phase), 0);
    chk("rstout_busy", int'(busy), 0);
    chk("rstout_overrun", int'(overrun), 0);
    chk("rstout_fault", int'(fault), 0);
    reset = 1'b0;
    cd_pv = -1; cd_calc = -1; cd_out = -1;
    out_done = 1'b1;
    step();
    chk("late_done_phase", int'(phase), 0);
    n = 1;
    while (!pv_start && n < 20) begin
      step();
      n++;
    end
    chk("rstout_resume_edges", n, 3);

    // en drops during PV: iteration completes, no new iteration
    apply_reset();
    start_run(9, 2, 2, 2);
    n = 0;
    for (int k = 0; k < 30 && n == 0; k++) begin
      step();
      if (pv_start) n = 1;
    end
    chk("en_pv_seen", n, 1);
    en = 1'b0;
    n_out = 0; n_pv = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (out_start) n_out++;
      if (pv_start) n_pv++;
    end
    chk("en_off_out_count", n_out, 1);
    chk("en_off_pv_count", n_pv, 0);
    chk("en_off_phase", int'(phase), 0);
    chk("en_off_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
